// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// (also intended for the companion transmitter) and a majority helper.
package uart_pkg;

  localparam int UART_OVERSAMPLING = 8;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_e;

  // 2-of-3 vote used to suppress single-sample noise on the line.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Input conditioning for the UART receiver: a 2-FF synchronizer on the
// asynchronous rxd line followed by a tick-gated 3-sample majority voter.
// Both stages reset to the idle (high) line level so that reset never
// looks like a start bit.
module uart_rx_filter
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_tick,
  input  logic rxd,
  output logic rx_bit
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;

  // Two-stage synchronizer for the asynchronous serial input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old
      // values on the same edge, which is what makes this a two-stage chain.
      sync_q <= {sync_q[0], rxd};
    end
  end

  // Sample history, advanced only on oversampling ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 3'b111;
    end else if (rx_tick) begin
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  assign rx_bit = majority3(hist_q);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1 by default). Detects a start bit,
// re-validates it at mid-bit, samples each data bit at mid-bit and checks
// the stop bit. Received bytes are presented as a one-cycle data_valid
// strobe with data_out held until the next good byte.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with an even
// parity check; otherwise parity_err is tied low. Ports are identical in
// both builds.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = UART_OVERSAMPLING,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLING);
  localparam int IDX_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLING - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_bit;

  uart_rx_filter u_filter (
    .clk     (clk),
    .rst     (rst),
    .rx_tick (rx_tick),
    .rxd     (rxd),
    .rx_bit  (rx_bit)
  );

  uart_rx_state_e       state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_ok_q;
  logic                 perr_q;
`endif

  // Frame FSM with counters, shift register and registered output strobes;
  // nothing but the strobe clear happens on non-tick cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      // NOTE: every register here has a reset value, including the data
      // path, so data_out is a defined 0 after reset rather than X.
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      if (rx_tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_bit) begin
              state_q <= START;
              cnt_q   <= '0;
            end
          end
          START: begin
            if (cnt_q == CNT_HALF) begin
              if (rx_bit) begin
                state_q <= IDLE;
              end else begin
                cnt_q   <= '0;
                idx_q   <= '0;
                state_q <= DATA;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DATA: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              shreg_q <= {rx_bit, shreg_q[DATA_BITS-1:1]};
              idx_q   <= idx_q + 1'b1;
              if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              // Even parity: data bits plus parity bit hold an even count of ones.
              par_ok_q <= (rx_bit == ^shreg_q);
              state_q  <= STOP;
            end
          end
`endif
          STOP: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              if (rx_bit) begin
                state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (par_ok_q) begin
                  data_q  <= shreg_q;
                  valid_q <= 1'b1;
                end else begin
                  perr_q  <= 1'b1;
                end
`else
                data_q  <= shreg_q;
                valid_q <= 1'b1;
`endif
              end else begin
                // Low stop bit: hold off until the line returns high so a
                // break is reported once instead of as a stream of 0x00 bytes.
                ferr_q  <= 1'b1;
                state_q <= WAIT_HIGH;
              end
            end
          end
          WAIT_HIGH: begin
            if (rx_bit) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign framing_err = ferr_q;
  assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Expected receiver events are queued when
// a frame is driven and compared by a monitor when the DUT strobes an output.
module tb_uart_rx;

  localparam int TICK_DIV = 4;               // clk cycles per rx_tick
  localparam int BIT_CLKS = TICK_DIV * 8;    // clk cycles per bit at OVERSAMPLING=8

  typedef enum {EV_VALID, EV_FERR, EV_PERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_tick = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_err;
  logic       parity_err;
  logic       busy;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  tick_cnt = 0;
  ev_t exp_q[$];
  ev_t mon_e;

  uart_rx #(.OVERSAMPLING(8), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_tick     (rx_tick),
    .rxd         (rxd),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Free-running tick generator: one-cycle strobe every TICK_DIV clocks.
  always @(posedge clk) begin
    tick_cnt <= (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
    rx_tick  <= (tick_cnt == TICK_DIV - 1);
  end

  // Scoreboard monitor: every output strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (data_valid || framing_err || parity_err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got valid=%0b ferr=%0b perr=%0b data=%h, required no event",
                 data_valid, framing_err, parity_err, data_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (data_valid !== (mon_e.kind == EV_VALID) ||
            framing_err !== (mon_e.kind == EV_FERR) ||
            parity_err !== (mon_e.kind == EV_PERR) ||
            (mon_e.kind == EV_VALID && data_out !== mon_e.data)) begin
          n_fail++;
          $display("FAIL event: got valid=%0b ferr=%0b perr=%0b data=%h, required %s data=%h",
                   data_valid, framing_err, parity_err, data_out, mon_e.kind.name(), mon_e.data);
        end
      end
    end
  end

  // Global watchdog so the run always terminates.
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_clks(BIT_CLKS);
  endtask

  // Drives start, LSB-first data, optional parity, then stop; rxd is left
  // at the stop level on return.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  task automatic send_good(input logic [7:0] d);
    ev_t e;
    e.kind = EV_VALID;
    e.data = d;
    exp_q.push_back(e);
    send_frame(d, ^d, 1'b1);
  endtask

  // Waits (bounded) for all expected events, then for the FSM to settle.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_busy: got %b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    wait_clks(4);
    n_checks++;
    if ({data_out, data_valid, framing_err, parity_err, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_values: got data=%h v=%b f=%b p=%b busy=%b, required all 0",
               data_out, data_valid, framing_err, parity_err, busy);
    end
    rst = 1'b0;
    wait_clks(BIT_CLKS);
    n_checks++;
    if (busy !== 1'b0 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b data=%h, required busy=0 data=00", busy, data_out);
    end
  endtask

  task automatic test_basic();
    send_good(8'h55);
    drain("basic");
    n_checks++;
    if (data_out !== 8'h55) begin
      n_fail++;
      $display("FAIL basic_hold: got %h, required 55", data_out);
    end
  endtask

  task automatic test_glitch();
    logic seen_busy;
    seen_busy = 1'b0;
    rxd = 1'b0;
    wait_clks(2 * TICK_DIV);
    rxd = 1'b1;
    for (int i = 0; i < 12 * TICK_DIV; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    n_checks++;
    if (seen_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_detected: got busy_seen=%b, required 1", seen_busy);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_idle: got busy=%b, required 0", busy);
    end
    n_checks++;
    if (data_out !== 8'h55) begin
      n_fail++;
      $display("FAIL glitch_hold: got %h, required 55", data_out);
    end
  endtask

  task automatic test_framing();
    ev_t e;
    e.kind = EV_FERR;
    e.data = 8'h00;
    exp_q.push_back(e);
    send_frame(8'hA3, ^8'hA3, 1'b0);
    wait_clks(3 * BIT_CLKS);          // break: line held low
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL framing_wait_high: got busy=%b, required 1", busy);
    end
    drain("framing");
    n_checks++;
    if (data_out !== 8'h55) begin
      n_fail++;
      $display("FAIL framing_hold: got %h, required 55", data_out);
    end
    send_good(8'h3C);
    drain("after_framing");
    n_checks++;
    if (data_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL after_framing_data: got %h, required 3c", data_out);
    end
  endtask

  task automatic test_back_to_back();
    send_good(8'h00);
    send_good(8'hFF);
    send_good(8'h81);
    drain("back_to_back");
    n_checks++;
    if (data_out !== 8'h81) begin
      n_fail++;
      $display("FAIL b2b_last: got %h, required 81", data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rxd = d[4];
    wait_clks(BIT_CLKS / 2);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_busy_before: got %b, required 1", busy);
    end
    rst = 1'b1;
    wait_clks(3);
    n_checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_abort: got busy=%b v=%b data=%h, required 0 0 00",
               busy, data_valid, data_out);
    end
    rst = 1'b0;
    rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
    send_good(8'h12);
    drain("midreset");
    n_checks++;
    if (data_out !== 8'h12) begin
      n_fail++;
      $display("FAIL midreset_next: got %h, required 12", data_out);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    ev_t e;
    e.kind = EV_PERR;
    e.data = 8'h00;
    exp_q.push_back(e);
    send_frame(8'h07, 1'b0, 1'b1);
    drain("parity_bad");
    n_checks++;
    if (data_out !== 8'h12) begin
      n_fail++;
      $display("FAIL parity_hold: got %h, required 12", data_out);
    end
    e.kind = EV_VALID;
    e.data = 8'h07;
    exp_q.push_back(e);
    send_frame(8'h07, 1'b1, 1'b1);
    drain("parity_good");
    n_checks++;
    if (data_out !== 8'h07) begin
      n_fail++;
      $display("FAIL parity_good_data: got %h, required 07", data_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    wait_clks(BIT_CLKS);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver; consumes the `tick` strobe of the baud tick generator (instantiated with `Oversampling = OVERSAMPLING`) and recovers 8N1 bytes from the asynchronous `rxd` line. It validates the start bit, samples each bit at mid-bit through a 3-sample majority filter and flags framing errors. It presents each received byte as a single-cycle strobe to the room-terminal command logic.

## Interface
- `OVERSAMPLING`, 8, ticks per bit; power of two, ≥4
- `DATA_BITS`, 8, data bits per frame, LSB first
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-high reset
- `rx_tick` in 1: one-cycle strobe at baud×OVERSAMPLING, from the tick generator
- `rxd` in 1: asynchronous serial input, idle high
- `data_out` out DATA_BITS: last good byte; holds until the next good byte
- `data_valid` out 1: one-cycle pulse; `data_out` is valid in the same cycle
- `framing_err` out 1: one-cycle pulse when a stop bit samples low
- `parity_err` out 1: one-cycle pulse on a parity mismatch (see Configuration)
- `busy` out 1: high in every state except IDLE

## Operation
- `rxd` passes a 2-FF synchronizer (reset value 1). On each `rx_tick`, the synchronized value shifts into a 3-bit history (reset 3'b111). `rx_bit` is the majority of that history.
- Tick counter `cnt` (log2(OVERSAMPLING) bits) and bit index `idx` advance only on `rx_tick`. No state changes occur on non-tick cycles.
- States:
  - IDLE: when `rx_tick` and `rx_bit==0`, go to START with `cnt` set to 0.
  - START: increment `cnt` on each tick. At `cnt==OVERSAMPLING/2-1`:
    - if `rx_bit==1`, the start is false; go to IDLE and emit no output.
    - otherwise set `cnt` to 0, set `idx` to 0 and go to DATA.
  - DATA: on the tick where `cnt==OVERSAMPLING-1`, shift `rx_bit` into the MSB of `shreg` (right shift, LSB first), increment `idx` and wrap `cnt` to 0. After the bit with `idx==DATA_BITS-1`, go to PARITY (when enabled) or STOP.
  - PARITY: sample at `cnt==OVERSAMPLING-1` and store `par_ok`, then go to STOP.
  - STOP: sample at `cnt==OVERSAMPLING-1`.
    - If `rx_bit==1`, go to IDLE.
    - If `rx_bit==0`, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE on the first tick with `rx_bit==1`. This prevents a break condition from being decoded as 0x00 frames.
- Stop sampled high, parity good (or parity disabled): load `data_out` with `shreg` and pulse `data_valid`.
- Stop sampled low: pulse `framing_err`; `data_out` and `data_valid` are untouched.
- Stop sampled high but parity bad: pulse `parity_err`; `data_out` is untouched.
- Width rule: `cnt` wraps naturally at OVERSAMPLING. `idx` is $clog2(DATA_BITS)+1 bits wide.

## Timing
- Reset values: state IDLE, `data_out` 0, `data_valid` 0, `framing_err` 0, `parity_err` 0, `busy` 0.
- Reset asserted mid-frame aborts immediately to IDLE with no output pulse.
- Latency:
  - Input path: 2 `clk` cycles from `rxd` to the synchronizer output, plus ≤2 ticks of majority delay.
  - Output: `data_valid` / `framing_err` / `parity_err` are registered and assert in the `clk` cycle after the stop-sampling tick, for exactly one cycle.
- Mid-bit sampling: data bit *k* is sampled (OVERSAMPLING/2 + (k+1)·OVERSAMPLING) ticks after the start detection tick.
- Back-to-back frames: a start edge immediately after the stop bit is accepted. IDLE is re-entered on the stop tick, and the next tick may detect the start.
- `rx_tick` held low: the FSM freezes in its current state. There is no timeout.
- No handshake or backpressure: a consumer must take `data_out` on `data_valid`. An unread byte is overwritten by the next good byte.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined:
  - PARITY state is present; even parity is checked over DATA_BITS.
  - `parity_err` is driven as described above.
  - Frame is 8E1.
- Undefined:
  - PARITY state is compiled out; DATA goes directly to STOP.
  - `parity_err` is tied to 0.
  - Frame is 8N1.
- The port list is identical in both builds.

## Structure
- `uart_pkg`:
  - state enum `uart_rx_state_e` {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}
  - defaults `UART_OVERSAMPLING=8` and `UART_DATA_BITS=8`, shared with the future `uart_tx`
- Sub-module `uart_rx_filter`: 2-FF synchronizer plus the tick-gated 3-sample majority voter; output `rx_bit`.
- The FSM, counters, shift register and output registers live in `uart_rx`.

## Test plan
- Byte 0x55 sent at OVERSAMPLING=8 with ideal ticks → a single `data_valid` pulse with `data_out==8'h55`; `framing_err` stays 0.
- A 2-tick low glitch on idle `rxd` → FSM returns to IDLE; no output pulse; `busy` drops within 4 ticks.
- Frame 0xA3 with the stop bit forced low, then line held low 3 bit-times → one `framing_err` pulse; no `data_valid`; `data_out` keeps its prior value; the next valid 0x3C is received correctly.
- Back-to-back 0x00, 0xFF, 0x81 with zero idle time → three `data_valid` pulses with correct values, in order.
- `rst` asserted during data bit 4 of 0xF0, then 0x12 sent → no pulse for the aborted frame; 0x12 is received.
- With `UART_RX_PARITY_EN` defined:
  - 0x07 with parity bit 1 → `data_valid`.
  - 0x07 with parity bit 0 → `parity_err` pulse; `data_out` unchanged.
